// File: rtl/pulse_meter_pkg.sv
// Shared constants for pulse_meter: FSM state encoding and default parameters.
package pulse_meter_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_ARM  = 3'd1;
    localparam logic [STATE_W-1:0] ST_HIGH = 3'd2;
    localparam logic [STATE_W-1:0] ST_LOW  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

    localparam int DEF_TICK_DIV = 100000;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_TIMEOUT  = 2000;

endpackage

// File: rtl/sig_sync_edge.sv
// Purpose: 2-FF synchronizer plus delay register producing one-cycle rise/fall strobes.
// Latency: strobes are sampled by downstream logic 3 clk edges after a pin edge; both edges equal.
// Backpressure: none; strobes are free-running and cannot be stalled.
module sig_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    assign rise = sync2 & ~dly;
    assign fall = ~sync2 & dly;

endmodule

// File: rtl/pulse_meter.sv
// Purpose: measures period and high time of a slow async input in prescaled ticks (PULSE_METER_CONTINUOUS_EN: back-to-back measurements).
// Latency: valid pulses the cycle after the terminating rise strobe, or the cycle after a phase timeout.
// Backpressure: none; start is ignored while busy, results hold until the next valid.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             timeout
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int PH_W  = $clog2(TIMEOUT + 1);

`ifdef PULSE_METER_CONTINUOUS_EN
    localparam bit CONT_EN = 1'b1;
`else
    localparam bit CONT_EN = 1'b0;
`endif

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;

    logic               rise;
    logic               fall;
    logic [PRE_W-1:0]   pre;
    logic               tick;
    logic [PH_W-1:0]    phase_cnt;
    logic [CNT_W-1:0]   period_cnt;
    logic [CNT_W-1:0]   cnt_now;
    logic [CNT_W-1:0]   high_cnt;

    logic measuring;
    logic timeout_hit;
    logic start_acc;
    logic arm_rise;
    logic fall_acc;
    logic meas_rise;
    logic cnt_inc;

    sig_sync_edge u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    assign tick        = (pre == PRE_W'(TICK_DIV - 1));
    assign measuring   = (state == ST_ARM) || (state == ST_HIGH) || (state == ST_LOW);
    // A timeout in the same cycle as a strobe takes priority over the strobe.
    assign timeout_hit = measuring && tick && (phase_cnt == PH_W'(TIMEOUT - 1));
    assign start_acc   = (state == ST_IDLE) && start;
    assign arm_rise    = (state == ST_ARM)  && rise && !timeout_hit;
    assign fall_acc    = (state == ST_HIGH) && fall && !timeout_hit;
    assign meas_rise   = (state == ST_LOW)  && rise && !timeout_hit;

    assign cnt_inc = tick && ((state == ST_HIGH) || (state == ST_LOW))
                     && (period_cnt != {CNT_W{1'b1}});
    assign cnt_now = cnt_inc ? period_cnt + 1'b1 : period_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_ARM;
            ST_ARM: begin
                if (timeout_hit)   next_state = ST_DONE;
                else if (rise)     next_state = ST_HIGH;
            end
            ST_HIGH: begin
                if (timeout_hit)   next_state = ST_DONE;
                else if (fall)     next_state = ST_LOW;
            end
            ST_LOW: begin
                if (timeout_hit)   next_state = ST_DONE;
                else if (rise)     next_state = ST_DONE;
            end
            ST_DONE: next_state = (CONT_EN && !timeout) ? ST_HIGH : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != ST_IDLE);
        valid = (state == ST_DONE);
    end

    // Clearing on start as well makes an ARM timeout land a fixed time after start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (start_acc || arm_rise || (CONT_EN && meas_rise) || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
        end else if (start_acc || arm_rise || fall_acc || meas_rise) begin
            phase_cnt <= '0;
        end else if (measuring && tick) begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else begin
            if (arm_rise || (CONT_EN && meas_rise)) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= cnt_now;
            end
            if (fall_acc) begin
                high_cnt <= cnt_now;
            end
        end
    end

    // Results are written on the way into DONE so they appear together with valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period    <= '0;
            high_time <= '0;
            timeout   <= 1'b0;
        end else if (timeout_hit) begin
            period    <= '0;
            high_time <= '0;
            timeout   <= 1'b1;
        end else if (meas_rise) begin
            period    <= cnt_now;
            high_time <= high_cnt;
            timeout   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed scenarios with a result scoreboard for pulse_meter (TICK_DIV=10, TIMEOUT=50).
module tb_pulse_meter;

    typedef struct {
        logic [31:0] p;
        logic [31:0] h;
        logic [31:0] t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sig_in = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       valid;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       timeout;

    logic       sig_s = 1'b0;
    logic       start_s = 1'b0;
    logic       busy_s;
    logic       valid_s;
    logic [3:0] period_s;
    logic [3:0] high_s;
    logic       timeout_s;

    int   errors = 0;
    int   checks = 0;
    int   valid_cnt = 0;
    int   cyc_cnt = 0;
    int   last_cyc = 0;
    bit   have_prev = 1'b0;
    exp_t q[$];
    exp_t q_s[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    pulse_meter #(.TICK_DIV(10), .CNT_W(8), .TIMEOUT(50)) u_dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .busy(busy),
        .valid(valid), .period(period), .high_time(high_time), .timeout(timeout)
    );

    pulse_meter #(.TICK_DIV(10), .CNT_W(4), .TIMEOUT(50)) u_sat (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_s), .start(start_s), .busy(busy_s),
        .valid(valid_s), .period(period_s), .high_time(high_s), .timeout(timeout_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q.size() + q_s.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(q.size() + q_s.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && valid) begin
            exp_t e;
            valid_cnt++;
            chk("valid_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("period", 32'(period), e.p);
                chk("high_time", 32'(high_time), e.h);
                chk("timeout", 32'(timeout), e.t);
            end
`ifdef PULSE_METER_CONTINUOUS_EN
            if (!timeout) begin
                if (have_prev) chk("valid_interval", 32'(cyc_cnt - last_cyc), 32'd200);
                have_prev = 1'b1;
                last_cyc  = cyc_cnt;
            end
`endif
        end
        if (rst_n && valid_s) begin
            exp_t e;
            chk("sat_valid_expected", 32'(q_s.size() > 0), 32'd1);
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                chk("sat_period", 32'(period_s), e.p);
                chk("sat_high_time", 32'(high_s), e.h);
                chk("sat_timeout", 32'(timeout_s), e.t);
            end
        end
    end

    initial begin
        int n;
        int vc;

        cyc(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_high_time", 32'(high_time), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        cyc(3);

`ifdef PULSE_METER_CONTINUOUS_EN
        pulse_start();
        cyc(5);
        for (int i = 0; i < 5; i++) q.push_back('{32'd20, 32'd10, 32'd0});
        q.push_back('{32'd0, 32'd0, 32'd1});
        for (int i = 0; i < 5; i++) begin
            sig_in = 1'b1;
            cyc(100);
            sig_in = 1'b0;
            cyc(100);
        end
        chk("cont_busy_held", 32'(busy), 32'd1);
        sig_in = 1'b1;
        cyc(100);
        sig_in = 1'b0;
        drain(1200);
        cyc(3);
        chk("cont_busy_after_timeout", 32'(busy), 32'd0);
`else
        // Basic measurement: 50 high, 150 low.
        pulse_start();
        cyc(3);
        chk("busy_after_start", 32'(busy), 32'd1);
        q.push_back('{32'd20, 32'd5, 32'd0});
        sig_in = 1'b1;
        cyc(50);
        sig_in = 1'b0;
        cyc(150);
        sig_in = 1'b1;
        drain(100);
        cyc(3);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("period_held", 32'(period), 32'd20);
        chk("valid_once", 32'(valid_cnt), 32'd1);

        // Quantization: 59 high, 60 low.
        sig_in = 1'b0;
        cyc(5);
        pulse_start();
        cyc(3);
        q.push_back('{32'd11, 32'd5, 32'd0});
        sig_in = 1'b1;
        cyc(59);
        sig_in = 1'b0;
        cyc(60);
        sig_in = 1'b1;
        drain(100);

        // Missing edge: no rise ever arrives.
        sig_in = 1'b0;
        cyc(5);
        q.push_back('{32'd0, 32'd0, 32'd1});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!valid && n < 700) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency_500_510", 32'(n >= 500 && n <= 510), 32'd1);
        drain(20);

        // Second start while busy must not disturb the measurement.
        pulse_start();
        cyc(3);
        q.push_back('{32'd10, 32'd3, 32'd0});
        sig_in = 1'b1;
        cyc(15);
        pulse_start();
        chk("busy_ignored_start", 32'(busy), 32'd1);
        cyc(14);
        sig_in = 1'b0;
        cyc(70);
        sig_in = 1'b1;
        drain(100);

        // Reset during HIGH aborts with no valid.
        sig_in = 1'b0;
        cyc(5);
        pulse_start();
        cyc(3);
        sig_in = 1'b1;
        cyc(20);
        vc = valid_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_period", 32'(period), 32'd0);
        chk("abort_high_time", 32'(high_time), 32'd0);
        chk("abort_timeout", 32'(timeout), 32'd0);
        cyc(10);
        sig_in = 1'b0;
        rst_n = 1'b1;
        cyc(30);
        chk("abort_no_valid", 32'(valid_cnt), 32'(vc));
        chk("abort_idle", 32'(busy), 32'd0);

        // Saturation on the 4-bit instance.
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        cyc(3);
        q_s.push_back('{32'd15, 32'd15, 32'd0});
        sig_s = 1'b1;
        cyc(300);
        sig_s = 1'b0;
        cyc(50);
        sig_s = 1'b1;
        drain(100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
